// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bundle: redirect, imem read port and decode-side instruction stream
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        input  redirect, redirect_pc, imem_resp, imem_rdata, instr_ready,
        output imem_read, imem_address, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_resp, imem_rdata, instr_ready,
        input  imem_read, imem_address, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher feeding a {pc, instr} queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_mem  [DEPTH];
    logic [31:0]      ins_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             has_room;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

    assign pop      = (count != '0) && bus.instr_ready;
    assign push     = (state == REQ) && bus.imem_resp && !bus.redirect;
    assign has_room = (count < FULL) || pop;

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? ins_mem[rd_ptr] : 32'd0;
    assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_ptr]  : 32'd0;

    // Queue storage carries no reset; count/pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= fetch_pc;
            ins_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            fetch_pc         <= RESET_PC;
            bus.imem_read    <= 1'b0;
            bus.imem_address <= 32'd0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
        end else begin
            // A redirect flushes the queue and wins over any same-cycle push or pop.
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            end

            case (state)
                IDLE: begin
                    if (!bus.redirect && has_room) begin
                        state            <= REQ;
                        bus.imem_read    <= 1'b1;
                        bus.imem_address <= fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.imem_resp) begin
                        state         <= IDLE;
                        bus.imem_read <= 1'b0;
                    end else if (bus.redirect) begin
                        // Keep the abandoned address on the bus until memory answers.
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.imem_resp) begin
                        state         <= IDLE;
                        bus.imem_read <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.imem_read <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a latency-programmable memory model
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0060), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          lat     = 0;
    int          mcnt    = 0;
    logic        mem_on  = 1'b0;
    logic        man_resp = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    logic        flag_a;
    logic        flag_b;
    int          n;

    always @(posedge clk) begin
        #2;
        if (!mem_on) begin
            bus.imem_resp  = man_resp;
            bus.imem_rdata = man_rdata;
            mcnt = 0;
        end else if (bus.imem_read) begin
            if (mcnt >= lat) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = bus.imem_address ^ KEY;
                mcnt = 0;
            end else begin
                bus.imem_resp = 1'b0;
                mcnt++;
            end
        end else begin
            bus.imem_resp = 1'b0;
            mcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_ins.push_back(bus.instr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        got_pc.delete();
        got_ins.delete();
        rst = 1'b0;
    endtask

    task automatic wait_read(input logic [31:0] addr, input string tag);
        int k = 0;
        while (!(bus.imem_read && bus.imem_address == addr) && k < 50) begin
            tick(1);
            k++;
        end
        check(tag, 32'(k < 50), 32'd1);
    endtask

    function automatic logic [31:0] qpc(input int i);
        if (i < got_pc.size()) return got_pc[i];
        return 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] qins(input int i);
        if (i < got_ins.size()) return got_ins[i];
        return 32'hDEAD_DEAD;
    endfunction

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.instr_ready = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        check("rst_read",  32'(bus.imem_read), 32'd0);
        check("rst_addr",  bus.imem_address, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_pc",    bus.instr_pc, 32'd0);

        // Straight-line fetch with a zero-wait memory and an always-ready decoder.
        mem_on = 1'b1;
        lat = 0;
        bus.instr_ready = 1'b1;
        rst = 1'b0;
        tick(1);
        check("first_read", 32'(bus.imem_read), 32'd1);
        check("first_addr", bus.imem_address, 32'h60);
        tick(8);
        for (int i = 0; i < 3; i++) begin
            check("seq_pc",  qpc(i),  32'h60 + 32'(4 * i));
            check("seq_ins", qins(i), (32'h60 + 32'(4 * i)) ^ KEY);
        end

        // Stalled decoder: queue fills, fetch stops, resumes at 0x70 on the first pop.
        bus.instr_ready = 1'b0;
        do_reset();
        tick(12);
        check("full_read",  32'(bus.imem_read), 32'd0);
        check("full_valid", 32'(bus.instr_valid), 32'd1);
        check("full_pc",    bus.instr_pc, 32'h60);
        check("full_ins",   bus.instr, 32'h60 ^ KEY);
        flag_a = 1'b0;
        repeat (4) begin
            tick(1);
            flag_a |= bus.imem_read;
        end
        check("full_hold", 32'(flag_a), 32'd0);
        bus.instr_ready = 1'b1;
        tick(1);
        check("resume_read", 32'(bus.imem_read), 32'd1);
        check("resume_addr", bus.imem_address, 32'h70);
        tick(10);
        for (int i = 0; i < 5; i++) begin
            check("drain_pc", qpc(i), 32'h60 + 32'(4 * i));
        end

        // Redirect while a slow request to 0x64 is outstanding.
        bus.instr_ready = 1'b0;
        lat = 3;
        do_reset();
        wait_read(32'h64, "wait_64");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h1003;
        tick(1);
        bus.redirect = 1'b0;
        check("disc_flush", 32'(bus.instr_valid), 32'd0);
        check("disc_read",  32'(bus.imem_read), 32'd1);
        check("disc_addr",  bus.imem_address, 32'h64);
        flag_a = 1'b0;
        flag_b = 1'b0;
        n = 0;
        while (bus.imem_read && n < 20) begin
            if (bus.imem_address != 32'h64) flag_a = 1'b1;
            flag_b |= bus.instr_valid;
            tick(1);
            n++;
        end
        check("disc_hold",  32'(flag_a), 32'd0);
        check("disc_drop",  32'(flag_b), 32'd0);
        check("disc_done",  32'(n < 20), 32'd1);
        tick(1);
        check("redir_read",  32'(bus.imem_read), 32'd1);
        check("redir_addr",  bus.imem_address, 32'h1000);
        check("redir_empty", 32'(bus.instr_valid), 32'd0);

        // Redirect in the same cycle as the response for 0x68.
        bus.instr_ready = 1'b1;
        lat = 0;
        do_reset();
        wait_read(32'h68, "wait_68");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h2000;
        got_pc.delete();
        got_ins.delete();
        tick(1);
        bus.redirect = 1'b0;
        check("same_read",  32'(bus.imem_read), 32'd0);
        check("same_valid", 32'(bus.instr_valid), 32'd0);
        tick(1);
        check("same_next_read", 32'(bus.imem_read), 32'd1);
        check("same_next_addr", bus.imem_address, 32'h2000);
        tick(4);
        check("same_first_pc",  qpc(0),  32'h2000);
        check("same_first_ins", qins(0), 32'h2000 ^ KEY);

        // Address wrap from 0xFFFF_FFFC to 0.
        bus.instr_ready = 1'b1;
        lat = 0;
        do_reset();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        tick(1);
        bus.redirect = 1'b0;
        check("wrap_idle", 32'(bus.imem_read), 32'd0);
        tick(1);
        check("wrap_addr", bus.imem_address, 32'hFFFF_FFFC);
        got_pc.delete();
        got_ins.delete();
        tick(2);
        check("wrap_next_read", 32'(bus.imem_read), 32'd1);
        check("wrap_next_addr", bus.imem_address, 32'h0);
        tick(4);
        check("wrap_pc0",  qpc(0),  32'hFFFF_FFFC);
        check("wrap_ins0", qins(0), 32'hFFFF_FFFC ^ KEY);
        check("wrap_pc1",  qpc(1),  32'h0);

        // Reset mid-request with two queued entries, then a stray response while idle.
        bus.instr_ready = 1'b0;
        lat = 0;
        do_reset();
        wait_read(32'h68, "wait_68b");
        lat = 20;
        check("mid_valid", 32'(bus.instr_valid), 32'd1);
        check("mid_pc",    bus.instr_pc, 32'h60);
        #3 rst = 1'b1;
        #1;
        check("arst_read",  32'(bus.imem_read), 32'd0);
        check("arst_addr",  bus.imem_address, 32'd0);
        check("arst_valid", 32'(bus.instr_valid), 32'd0);
        check("arst_instr", bus.instr, 32'd0);
        check("arst_pc",    bus.instr_pc, 32'd0);
        mem_on = 1'b0;
        man_resp = 1'b0;
        tick(2);
        rst = 1'b0;
        man_resp = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        tick(1);
        man_resp = 1'b0;
        check("late_read",  32'(bus.imem_read), 32'd1);
        check("late_addr",  bus.imem_address, 32'h60);
        check("late_valid", 32'(bus.instr_valid), 32'd0);
        tick(1);
        check("late_wait_valid", 32'(bus.instr_valid), 32'd0);
        lat = 0;
        mem_on = 1'b1;
        tick(1);
        check("late_deliver_valid", 32'(bus.instr_valid), 32'd1);
        check("late_deliver_pc",    bus.instr_pc, 32'h60);
        check("late_deliver_ins",   bus.instr, 32'h60 ^ KEY);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0060, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the fetch-queue entry count (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port redirect, input, 1, taken branch/jump/flush request.
REQ-006 SHALL have port redirect_pc, input, 32, the new fetch target.
REQ-007 SHALL have port imem_read, output, 1, instruction memory read request.
REQ-008 SHALL have port imem_address, output, 32, the read address.
REQ-009 SHALL have port imem_resp, input, 1, read completion, valid for one cycle.
REQ-010 SHALL have port imem_rdata, input, 32, read data, valid when imem_resp=1.
REQ-011 SHALL have port instr_valid, output, 1, queue head is valid.
REQ-012 SHALL have port instr_ready, input, 1, decode accepts the head.
REQ-013 SHALL have port instr, output, 32, head instruction word.
REQ-014 SHALL have port instr_pc, output, 32, head instruction address.

Function
REQ-015 SHALL hold fetch_pc (32 bit), a DEPTH-entry FIFO of {pc, instr}, and a 3-state FSM: IDLE, REQ, DISCARD.
REQ-016 SHALL drive imem_read=1 in REQ and DISCARD only, with imem_address held stable until imem_resp.
REQ-017 SHALL drive imem_address=fetch_pc in REQ; in DISCARD it SHALL hold the address of the abandoned request.
REQ-018 SHALL keep at most one memory request outstanding.
REQ-019 IDLE->REQ SHALL occur when FIFO count < DEPTH (counting a same-cycle pop) and redirect=0.
REQ-020 In REQ with imem_resp=1 and redirect=0, SHALL push {fetch_pc, imem_rdata}, set fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC -> 0), and go to IDLE.
REQ-021 On redirect=1, SHALL flush the FIFO (count=0, instr_valid=0 next cycle) and load fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-022 A redirect in REQ with imem_resp=0 SHALL go to DISCARD; a redirect in IDLE, or in REQ with imem_resp=1, SHALL go to IDLE and drop that response.
REQ-023 DISCARD SHALL go to IDLE on imem_resp and SHALL drop the data; a further redirect in DISCARD SHALL update fetch_pc and remain in DISCARD.
REQ-024 Redirect SHALL have priority over push and pop in the same cycle; the head consumed by a same-cycle pop is lost.
REQ-025 SHALL drive instr_valid=1 iff count>0, with instr/instr_pc showing the head; pop SHALL occur on instr_valid & instr_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order; a full FIFO SHALL never be pushed.
REQ-027 instr/instr_pc SHALL be 0 when instr_valid=0.
REQ-028 Delivery latency: REQ->IDLE on resp, then instr_valid=1 on the next cycle (registered FIFO).

Reset
REQ-029 While rst=1, SHALL asynchronously force fetch_pc=RESET_PC, FIFO empty, FSM=IDLE, imem_read=0, instr_valid=0, instr=0, instr_pc=0.
REQ-030 Reset during an outstanding request SHALL abandon it; a late imem_resp after release while in IDLE SHALL be ignored.
REQ-031 First imem_read=1 SHALL assert one cycle after rst deasserts, at address RESET_PC.

Verification
REQ-032 Reset release, 1-cycle memory, instr_ready=1 -> instr_pc sequence 0x60, 0x64, 0x68 in order with matching rdata.
REQ-033 instr_ready=0, DEPTH=4 -> exactly 4 pushes (0x60..0x6C), then imem_read stays 0; instr_ready=1 then resumes fetch at 0x70.
REQ-034 Redirect to 0x1003 while a request to 0x64 waits 3 cycles -> imem_address held at 0x64 until resp, data dropped, next request at 0x1000, FIFO empty.
REQ-035 Redirect in the same cycle as imem_resp for 0x68 -> 0x68 never delivered, next request at redirect target.
REQ-036 fetch_pc=0xFFFF_FFFC -> delivered instr_pc 0xFFFF_FFFC, then next request at 0x0000_0000.
REQ-037 rst asserted mid-REQ with FIFO holding 2 entries -> all outputs 0 immediately, first request after release at 0x60.
